// File: rtl/machine_timer.sv
// machine_timer: 64-bit mtime/mtimecmp timer with prescaler and level irq.
// Optional MACHINE_TIMER_SNAPSHOT_EN: MTIME_LO read latches mtime[63:32].
module machine_timer #(
  parameter int PRESCALE_WIDTH = 8,
  parameter bit RESET_ENABLE   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_select,
  input  logic        bus_write_enable,
  input  logic [4:0]  bus_address,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_read_valid,
  output logic        timer_interrupt_request
);

  localparam logic [2:0] A_MT_LO  = 3'd0;
  localparam logic [2:0] A_MT_HI  = 3'd1;
  localparam logic [2:0] A_CMP_LO = 3'd2;
  localparam logic [2:0] A_CMP_HI = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = 1;

  logic [63:0]               mtime;
  logic [63:0]               mtimecmp;
  logic [PRESCALE_WIDTH-1:0] prescale_count;
  logic [PRESCALE_WIDTH-1:0] divider;
  logic                      enable;
  logic                      tick;
  logic                      wr;
  logic                      rd;
  logic [2:0]                word;
  logic [31:0]               ctrl_word;
  logic [31:0]               mtime_hi_view;
  logic [31:0]               read_mux;

  assign word = bus_address[4:2];
  assign wr   = bus_select & bus_write_enable;
  assign rd   = bus_select & ~bus_write_enable;
  assign tick = enable & (prescale_count == divider);

`ifdef MACHINE_TIMER_SNAPSHOT_EN
  logic [31:0] shadow;

  // Capture the high word when the low word is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (rd && word == A_MT_LO) begin
      shadow <= mtime[63:32];
    end
  end

  assign mtime_hi_view = shadow;
`else
  assign mtime_hi_view = mtime[63:32];
`endif

  // Assemble the CTRL view from enable and divider.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[0] = enable;
    ctrl_word[8 +: PRESCALE_WIDTH] = divider;
  end

  // Select the register addressed by the current request.
  always_comb begin
    read_mux = '0;
    case (word)
      A_MT_LO:  read_mux = mtime[31:0];
      A_MT_HI:  read_mux = mtime_hi_view;
      A_CMP_LO: read_mux = mtimecmp[31:0];
      A_CMP_HI: read_mux = mtimecmp[63:32];
      A_CTRL:   read_mux = ctrl_word;
      default:  read_mux = '0;
    endcase
  end

  // Control register and prescaler; a CTRL write restarts the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable         <= RESET_ENABLE;
      divider        <= '0;
      prescale_count <= '0;
    end else if (wr && word == A_CTRL) begin
      enable         <= bus_write_data[0];
      divider        <= bus_write_data[8 +: PRESCALE_WIDTH];
      prescale_count <= '0;
    end else if (enable) begin
      prescale_count <= tick ? '0 : prescale_count + P_ONE;
    end
  end

  // mtime: a write to either half suppresses that cycle's tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr && word == A_MT_LO) begin
      mtime[31:0] <= bus_write_data;
    end else if (wr && word == A_MT_HI) begin
      mtime[63:32] <= bus_write_data;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp halves are plain software registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= '1;
    end else if (wr && word == A_CMP_LO) begin
      mtimecmp[31:0] <= bus_write_data;
    end else if (wr && word == A_CMP_HI) begin
      mtimecmp[63:32] <= bus_write_data;
    end
  end

  // Registered level interrupt from the unsigned compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_interrupt_request <= 1'b0;
    end else begin
      timer_interrupt_request <= (mtime >= mtimecmp);
    end
  end

  // One-cycle read response; data holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_read_data  <= '0;
      bus_read_valid <= 1'b0;
    end else begin
      bus_read_valid <= rd;
      if (rd) begin
        bus_read_data <= read_mux;
      end
    end
  end

endmodule
